// File: rtl/dma_periph_port.sv
// Peripheral end of a DREQ/DACK DMA handshake: byte FIFO between a device and the
// DMA bus, block-length counting, completion interrupt and sticky protocol error.
module dma_periph_port #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LENW  = 16
) (
  input  logic            cl,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dir,
  input  logic [LENW-1:0] len,
  input  logic            dev_in_valid,
  input  logic [7:0]      dev_in_data,
  output logic            dev_in_ready,
  output logic            dev_out_valid,
  output logic [7:0]      dev_out_data,
  input  logic            dev_out_ready,
  output logic            DREQ,
  input  logic            DACK,
  input  logic            ior,
  input  logic            iow,
  input  logic [7:0]      data_in,
  output logic [7:0]      data_out,
  output logic            data_oe,
  output logic            busy,
  output logic            done_irq,
  output logic            err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [LENW-1:0] rem;
  logic            dir_q, dir_next;
  logic            rd_s, wr_s, armed, drain, full, empty;
  logic            dma_pop, dma_push, dev_push, dev_pop, push, pop;
  logic            strobe_err, rem_dec, last, start_ok;
  logic            dreq_d, done_d;

  assign data_out     = mem[rd_ptr];
  assign dev_out_data = mem[rd_ptr];

  // Strobe decode, FIFO handshakes and next occupancy.
  always_comb begin
    rd_s          = DACK & ~ior;
    wr_s          = DACK & ~iow;
    armed         = (state == ARMED);
    drain         = (state == DRAIN);
    full          = (count == CW'(DEPTH));
    empty         = (count == '0);
    start_ok      = (state == IDLE) & start;
    dma_pop       = armed & rd_s & ~wr_s & ~dir_q & ~empty;
    dma_push      = armed & wr_s & ~rd_s & dir_q & ~full;
    strobe_err    = armed & (rd_s | wr_s) & ~(dma_pop | dma_push);
    dev_in_ready  = armed & ~dir_q & ~full;
    dev_push      = dev_in_valid & dev_in_ready;
    dev_out_valid = (armed | drain) & dir_q & ~empty;
    dev_pop       = dev_out_valid & dev_out_ready;
    push          = dev_push | dma_push;
    pop           = dev_pop | dma_pop;
    rem_dec       = dma_pop | dma_push;
    last          = rem_dec & (rem == LENW'(1));
    count_next    = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);
  end

  // State register.
  always_ff @(posedge cl) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && (len != '0)) state_next = ARMED;
      ARMED:   if (last) state_next = dir_q ? DRAIN : IDLE;
      DRAIN:   if (count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; DREQ and done_irq are computed here and registered below.
  always_comb begin
    busy     = (state != IDLE);
    data_oe  = rd_s & ~dir_q & armed;
    dir_next = start_ok ? dir : dir_q;
    done_d   = 1'b0;
    case (state)
      IDLE:    done_d = start & (len == '0);
      ARMED:   done_d = last & ~dir_q;
      DRAIN:   done_d = (count_next == '0);
      default: done_d = 1'b0;
    endcase
    dreq_d = (state_next == ARMED) &&
             (dir_next ? (count_next <= CW'(DEPTH - 1)) : (count_next != '0));
  end

  // FIFO pointers, block counter and registered status.
  always_ff @(posedge cl) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rem      <= '0;
      dir_q    <= 1'b0;
      DREQ     <= 1'b0;
      done_irq <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      dir_q    <= dir_next;
      DREQ     <= dreq_d;
      done_irq <= done_d;
      if (start_ok && (len != '0)) rem <= len;
      else if (rem_dec)            rem <= rem - LENW'(1);
      if (start_ok)                err <= 1'b0;
      else if (strobe_err)         err <= 1'b1;
    end
  end

  // Storage has no reset; occupancy is tracked by count.
  always_ff @(posedge cl) begin
    if (push) mem[wr_ptr] <= dev_push ? dev_in_data : data_in;
  end

endmodule

// File: doc/dma_periph_port.md
Name: dma_periph_port

Overview:
- Peripheral-side end of the DREQ/DACK DMA handshake: the requester/responder that sits between a device (disk-like byte source/sink) and the dma controller.
- Buffers bytes in a small FIFO and raises DREQ when it can service a transfer.
- Sources bytes on the data bus during DMA IO-read strobes; sinks bytes during DMA IO-write strobes.
- Counts the programmed block length and pulses an interrupt at completion.

Parameters:
- DEPTH, 8, FIFO depth in bytes (power of 2, at least 2)
- LENW, 16, width of block-length counter

Ports:
- cl  input  1  system clock, all state updated on posedge
- rst_n  input  1  synchronous active-low reset, sampled on posedge cl
- start  input  1  one-cycle pulse that arms a block transfer; ignored unless in IDLE
- dir  input  1  sampled at start: 0 = device->memory (DMA uses ior), 1 = memory->device (DMA uses iow)
- len  input  LENW  sampled at start: number of bytes in block; 0 means no transfer
- dev_in_valid  input  1  device offers byte (dir=0)
- dev_in_data  input  8  device byte
- dev_in_ready  output  1  FIFO accepts byte: not full and active with dir=0
- dev_out_valid  output  1  FIFO has byte for device (dir=1): not empty
- dev_out_data  output  8  FIFO head byte
- dev_out_ready  input  1  device consumes byte
- DREQ  output  1  DMA request to controller
- DACK  input  1  DMA acknowledge from controller
- ior  input  1  active-low IO read strobe (DMA reads from this port)
- iow  input  1  active-low IO write strobe (DMA writes to this port)
- data_in  input  8  bus data during iow strobe
- data_out  output  8  bus data during ior strobe
- data_oe  output  1  bus drive enable
- busy  output  1  high in ARMED/DRAIN
- done_irq  output  1  one-cycle completion pulse
- err  output  1  sticky protocol error flag

Behaviour:
- Reset: rst_n=0 at posedge cl -> state IDLE, FIFO emptied (rd/wr pointers and count = 0), byte counter 0, DREQ=0, done_irq=0, err=0, busy=0.
- Reset mid-block aborts with no done_irq.
- States: IDLE, ARMED, DRAIN.
- IDLE:
  - start with len!=0 -> ARMED; latch dir and len into remaining counter.
  - start with len=0 -> done_irq pulses next cycle, stay IDLE.
- Rd-strobe = DACK & !ior. Wr-strobe = DACK & !iow. Both in the same cycle -> err set, neither acts.
- DREQ is registered and asserted in ARMED only.
  - dir=0: DREQ=1 when FIFO count >= 1 after the current cycle's updates.
  - dir=1: DREQ=1 when FIFO count <= DEPTH-1 after the current cycle's updates.
  - DREQ falls the cycle after the condition fails, i.e. in demand mode DREQ stays high across consecutive strobes.
- data_out = FIFO head, combinational. data_oe = rd-strobe & dir_latched=0 & state ARMED.
- At posedge with rd-strobe (dir=0):
  - FIFO not empty: pop one byte, decrement remaining.
  - FIFO empty: err set, no pop.
- At posedge with wr-strobe (dir=1):
  - FIFO not full: push data_in, decrement remaining.
  - FIFO full: err set, byte dropped.
- A strobe whose direction mismatches dir_latched -> err set, no action. Strobes in IDLE/DRAIN are ignored and do not set err.
- Device side:
  - dir=0: push on dev_in_valid & dev_in_ready.
  - dir=1: pop on dev_out_valid & dev_out_ready.
  - Device push and DMA pop in the same cycle (or DMA push and device pop) -> count unchanged; pointers both advance.
  - Device handshakes are valid in ARMED and also in DRAIN for dir=1.
- Remaining reaching 0:
  - dir=0: -> IDLE, done_irq=1 for one cycle; bytes left in the FIFO are kept.
  - dir=1: -> DRAIN, DREQ=0; DRAIN -> IDLE with done_irq once the FIFO empties via device pops.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- err clears only on reset or on a start accepted in IDLE.

Test Plan:
- dir=0, len=4, device pushes 0x11,0x22,0x33,0x44 -> DREQ rises one cycle after first push; 4 rd-strobes see data_out 0x11..0x44 with data_oe=1; done_irq single pulse; DREQ=0; busy=0.
- dir=1, len=3, wr-strobes with data_in 0xA0,0xA1,0xA2, device ready held low -> DRAIN; set ready -> dev_out_data 0xA0,0xA1,0xA2 in order; done_irq after third pop.
- dir=1, DEPTH=8, len=10, device stalled -> DREQ drops after 8 pushes; a 9th wr-strobe sets err and count stays 8.
- dir=0, rd-strobe while FIFO empty -> err=1, remaining unchanged; next start in IDLE clears err.
- Simultaneous device push and rd-strobe at count=2 for 5 cycles -> count stays 2, byte order preserved across pointer wrap.
- rst_n=0 mid-block, dir=0, remaining=3, FIFO count=2 -> next cycle DREQ=0, count=0, IDLE, no done_irq; start with len=0 -> done_irq pulse.
